despacho_registradores: RTL

Write-side dispatcher paired with the register-file writeback mux: takes a value read from the register file and routes it out to one destination (data memory store, output port, HD write, or PC load) selected by the same 3-bit `controle` encoding the writeback path uses. Memory, output and PC writes are single-cycle registered pulses. HD writes use a req/ack handshake with an optional timeout, during which the block stalls the control unit.

---
 rtl/despacho_registradores.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/despacho_registradores.sv
// despacho_registradores: routes a register-file read value to memory, output port, HD or PC by `controle`.
// Latency: request accepted at edge N, strobe / hd_req valid from N+1.
// Backpressure: `ocupado` stalls the control unit while an HD write awaits hd_ack; other destinations accept every cycle.
//
// Ports:
//   clock, reset       single rising-edge clock, synchronous active-high reset
//   inicio, controle   request valid and destination (001 mem, 011 output, 010 HD, 100 PC, others none)
//   dado_reg, endereco value to write and target address
//   mem_*              memory store strobe + data/address
//   saida_*            output-port strobe + latched value
//   hd_*               HD write req/ack handshake, data/address held while hd_req=1
//   pc_*               PC load strobe + value
//   ocupado, erro_hd   stall while HD write outstanding; sticky HD timeout flag
//
// Optional feature: define HD_TIMEOUT_EN to build the hd_ack timeout counter and erro_hd.
// Without it the HD wait is unbounded, erro_hd is 0 and HD_TIMEOUT is unused.
module despacho_registradores #(
    parameter int DATA_W     = 32,
    parameter int HD_TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inicio,
    input  logic [2:0]        controle,
    input  logic [DATA_W-1:0] dado_reg,
    input  logic [DATA_W-1:0] endereco,
    output logic              ocupado,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_dado,
    output logic [DATA_W-1:0] mem_endereco,
    output logic              saida_valido,
    output logic [DATA_W-1:0] saida_dado,
    output logic              hd_req,
    input  logic              hd_ack,
    output logic [DATA_W-1:0] hd_dado,
    output logic [DATA_W-1:0] hd_endereco,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_dado,
    output logic              erro_hd
);

    localparam logic [2:0] CTL_MEM   = 3'b001;
    localparam logic [2:0] CTL_SAIDA = 3'b011;
    localparam logic [2:0] CTL_HD    = 3'b010;
    localparam logic [2:0] CTL_PC    = 3'b100;

    typedef enum logic {
        OCIOSO    = 1'b0,
        HD_ESPERA = 1'b1
    } estado_t;

    estado_t estado;
    estado_t estado_prox;

    logic aceita;
    logic hd_inicia;   // HD request accepted this cycle
    logic hd_conclui;  // ack seen while waiting
    logic hd_expira;   // wait budget exhausted without ack
    logic hd_estouro;  // counter sits at its limit

    // Stall is a pure state decode so it never glitches with inputs.
    assign ocupado = (estado == HD_ESPERA);
    assign aceita  = inicio && !ocupado;

`ifdef HD_TIMEOUT_EN
    localparam int CNT_W = (HD_TIMEOUT > 0) ? $clog2(HD_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HD_TIMEOUT);

    logic [CNT_W-1:0] contador;
    logic             erro_q;

    assign hd_estouro = (contador == CNT_MAX);
    assign erro_hd    = erro_q;

    // Counter saturates at CNT_MAX; reaching it ends the wait, so it never wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            contador <= '0;
            erro_q   <= 1'b0;
        end else begin
            if (hd_inicia) begin
                contador <= '0;
            end else if ((estado == HD_ESPERA) && !hd_ack && !hd_estouro) begin
                contador <= contador + CNT_W'(1);
            end
            if (hd_expira) begin
                erro_q <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;
    assign unused_timeout = (HD_TIMEOUT != 0);
    assign hd_estouro     = 1'b0;
    assign erro_hd        = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    // Ack takes priority over the timeout so a late-but-valid ack never flags an error.
    always_comb begin
        estado_prox = estado;
        hd_inicia   = 1'b0;
        hd_conclui  = 1'b0;
        hd_expira   = 1'b0;
        case (estado)
            OCIOSO: begin
                if (aceita && (controle == CTL_HD)) begin
                    hd_inicia   = 1'b1;
                    estado_prox = HD_ESPERA;
                end
            end
            HD_ESPERA: begin
                if (hd_ack) begin
                    hd_conclui  = 1'b1;
                    estado_prox = OCIOSO;
                end else if (hd_estouro) begin
                    hd_expira   = 1'b1;
                    estado_prox = OCIOSO;
                end
            end
            default: estado_prox = OCIOSO;
        endcase
    end

    // Strobes default low every cycle; data registers move only on their own command.
    always_ff @(posedge clock) begin
        if (reset) begin
            mem_we       <= 1'b0;
            mem_dado     <= '0;
            mem_endereco <= '0;
            saida_valido <= 1'b0;
            saida_dado   <= '0;
            pc_load      <= 1'b0;
            pc_dado      <= '0;
            hd_req       <= 1'b0;
            hd_dado      <= '0;
            hd_endereco  <= '0;
        end else begin
            mem_we       <= 1'b0;
            saida_valido <= 1'b0;
            pc_load      <= 1'b0;
            if (aceita) begin
                case (controle)
                    CTL_MEM: begin
                        mem_we       <= 1'b1;
                        mem_dado     <= dado_reg;
                        mem_endereco <= endereco;
                    end
                    CTL_SAIDA: begin
                        saida_valido <= 1'b1;
                        saida_dado   <= dado_reg;
                    end
                    CTL_PC: begin
                        pc_load <= 1'b1;
                        pc_dado <= dado_reg;
                    end
                    default: begin
                    end
                endcase
            end
            if (hd_inicia) begin
                hd_req      <= 1'b1;
                hd_dado     <= dado_reg;
                hd_endereco <= endereco;
            end else if (hd_conclui || hd_expira) begin
                hd_req <= 1'b0;
            end
        end
    end

endmodule
